// File: rtl/fb_pkg.sv
// ----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer write-port controller:
//   COORD_W              width of every x/y coordinate
//   FB_W_DEF / FB_H_DEF  default sweep geometry (pixels per row, rows)
//   FB_DATA_W            width of the wdata field in the write-bus struct;
//                        any COLOR_W up to this value fits
//   ST_* / fb_state_e    controller FSM encodings
//   fb_wbus_t            one frame-buffer write (we, x, y, wdata)
//   fb_write()           builds an asserted write-bus value
// ----------------------------------------------------------------------------
package fb_pkg;

    localparam int COORD_W   = 11;
    localparam int FB_W_DEF  = 240;
    localparam int FB_H_DEF  = 525;
    localparam int FB_DATA_W = 32;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
    localparam logic [1:0] ST_CLEAR     = 2'd2;

    typedef enum logic [1:0] {
        FB_IDLE      = ST_IDLE,
        FB_WAIT_SYNC = ST_WAIT_SYNC,
        FB_CLEAR     = ST_CLEAR
    } fb_state_e;

    typedef struct packed {
        logic                 we;
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
        logic [FB_DATA_W-1:0] wdata;
    } fb_wbus_t;

    function automatic fb_wbus_t fb_write(input logic [COORD_W-1:0]   x,
                                          input logic [COORD_W-1:0]   y,
                                          input logic [FB_DATA_W-1:0] wdata);
        fb_wbus_t w;
        w.we    = 1'b1;
        w.x     = x;
        w.y     = y;
        w.wdata = wdata;
        return w;
    endfunction

endpackage

// File: rtl/fb_clear_sweep.sv
// ----------------------------------------------------------------------------
// fb_clear_sweep
// Raster position counter for the clear pass. Holds the coordinate of the
// write currently on the bus; x runs fastest, y advances when x wraps.
//   clock_i      system clock
//   reset_i      synchronous active-high reset (position -> 0,0)
//   start_i      load position (0,0)
//   step_i       advance to the successor position
//   x_succ_o     x of the position following the current one
//   y_succ_o     y of the position following the current one
//   last_o       current position is (FB_W-1, FB_H-1)
// The successor is derived from the held position only, so the controller
// can use it in the same cycle it decides to step without a comb loop.
// ----------------------------------------------------------------------------
module fb_clear_sweep
    import fb_pkg::*;
#(
    parameter int FB_W = FB_W_DEF,
    parameter int FB_H = FB_H_DEF
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               step_i,
    output logic [COORD_W-1:0] x_succ_o,
    output logic [COORD_W-1:0] y_succ_o,
    output logic               last_o
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(FB_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(FB_H - 1);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    always_comb begin
        x_succ_o = x_q + COORD_W'(1);
        y_succ_o = y_q;
        if (x_q == X_MAX) begin
            x_succ_o = '0;
            y_succ_o = (y_q == Y_MAX) ? '0 : y_q + COORD_W'(1);
        end
    end

    assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start_i) begin
            x_d = '0;
            y_d = '0;
        end else if (step_i) begin
            x_d = x_succ_o;
            y_d = y_succ_o;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// ----------------------------------------------------------------------------
// fb_write_ctrl
// Owns the single frame-buffer write port and shares it between the clear
// sweep and the drawing client. Clear requests always win over draws; a
// request arriving while a clear is waiting or running is merged into one
// pending bit and serviced by a back-to-back sweep.
//
// Optional feature (macro FB_CLEAR_SYNC_EN): a clear first parks in
// WAIT_SYNC, still accepting draws, and starts sweeping the cycle after
// vsync. Without the macro vsync is ignored.
//
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   clear_req               one-cycle full-clear request
//   vsync                   one-cycle frame-start pulse
//   draw_valid/draw_ready   draw handshake (draw_ready is combinational)
//   draw_x, draw_y          draw coordinates
//   draw_color              draw pixel value
//   fb_we, fb_x, fb_y       registered write strobe and coordinates
//   fb_wdata                registered write data
//   busy                    registered: clear waiting, running or pending
//   clear_done              registered one-cycle pulse after the last write
// ----------------------------------------------------------------------------
module fb_write_ctrl
    import fb_pkg::*;
#(
    parameter int                 FB_W        = FB_W_DEF,
    parameter int                 FB_H        = FB_H_DEF,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_req,
    input  logic               vsync,
    input  logic               draw_valid,
    output logic               draw_ready,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COLOR_W-1:0] draw_color,
    output logic               fb_we,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic               busy,
    output logic               clear_done
);

    localparam logic [FB_DATA_W-1:0] CLR_WORD = FB_DATA_W'(CLEAR_COLOR);

    fb_state_e state_q, state_d;
    logic      pending_q, pending_d;
    fb_wbus_t  fb_q, fb_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      ready_c;

    logic               sweep_start;
    logic               sweep_step;
    logic [COORD_W-1:0] sweep_x_succ;
    logic [COORD_W-1:0] sweep_y_succ;
    logic               sweep_last;

    fb_clear_sweep #(
        .FB_W (FB_W),
        .FB_H (FB_H)
    ) u_sweep (
        .clock_i  (clock),
        .reset_i  (reset),
        .start_i  (sweep_start),
        .step_i   (sweep_step),
        .x_succ_o (sweep_x_succ),
        .y_succ_o (sweep_y_succ),
        .last_o   (sweep_last)
    );

`ifndef FB_CLEAR_SYNC_EN
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        fb_d        = fb_q;
        fb_d.we     = 1'b0;
        done_d      = 1'b0;
        sweep_start = 1'b0;
        sweep_step  = 1'b0;
        ready_c     = 1'b0;

        unique case (state_q)
            FB_IDLE: begin
                ready_c = !clear_req && !pending_q;
                if (clear_req || pending_q) begin
                    pending_d = 1'b0;
`ifdef FB_CLEAR_SYNC_EN
                    state_d = FB_WAIT_SYNC;
`else
                    // Issue (0,0) now so it is on the bus next cycle.
                    state_d     = FB_CLEAR;
                    sweep_start = 1'b1;
                    fb_d        = fb_write('0, '0, CLR_WORD);
`endif
                end else if (draw_valid) begin
                    fb_d = fb_write(draw_x, draw_y, FB_DATA_W'(draw_color));
                end
            end

`ifdef FB_CLEAR_SYNC_EN
            FB_WAIT_SYNC: begin
                if (clear_req) begin
                    pending_d = 1'b1;
                end
                if (vsync) begin
                    state_d     = FB_CLEAR;
                    sweep_start = 1'b1;
                    fb_d        = fb_write('0, '0, CLR_WORD);
                end else begin
                    ready_c = 1'b1;
                    if (draw_valid) begin
                        fb_d = fb_write(draw_x, draw_y, FB_DATA_W'(draw_color));
                    end
                end
            end
`endif

            FB_CLEAR: begin
                if (clear_req) begin
                    pending_d = 1'b1;
                end
                if (!sweep_last) begin
                    sweep_step = 1'b1;
                    fb_d       = fb_write(sweep_x_succ, sweep_y_succ, CLR_WORD);
                end else begin
                    // Last write is on the bus this cycle; a request seen
                    // now or earlier chains straight into the next sweep.
                    done_d = 1'b1;
                    if (pending_q || clear_req) begin
                        pending_d = 1'b0;
`ifdef FB_CLEAR_SYNC_EN
                        state_d = FB_WAIT_SYNC;
`else
                        sweep_start = 1'b1;
                        fb_d        = fb_write('0, '0, CLR_WORD);
`endif
                    end else begin
                        state_d = FB_IDLE;
                    end
                end
            end

            default: begin
                state_d   = FB_IDLE;
                pending_d = 1'b0;
            end
        endcase

        busy_d = (state_d != FB_IDLE) || pending_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FB_IDLE;
            pending_q <= 1'b0;
            fb_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            fb_q      <= fb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    logic [FB_DATA_W-1:0] unused_wdata;
    assign unused_wdata = fb_q.wdata;

    assign draw_ready = ready_c;
    assign fb_we      = fb_q.we;
    assign fb_x       = fb_q.x;
    assign fb_y       = fb_q.y;
    assign fb_wdata   = fb_q.wdata[COLOR_W-1:0];
    assign busy       = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
module tb_fb_write_ctrl;

    localparam int        FB_W = 4;
    localparam int        FB_H = 3;
    localparam int        NPIX = FB_W * FB_H;
    localparam logic [7:0] CLR = 8'h3C;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        vsync;
    logic        draw_valid;
    logic        draw_ready;
    logic [10:0] draw_x;
    logic [10:0] draw_y;
    logic [7:0]  draw_color;
    logic        fb_we;
    logic [10:0] fb_x;
    logic [10:0] fb_y;
    logic [7:0]  fb_wdata;
    logic        busy;
    logic        clear_done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    fb_write_ctrl #(
        .FB_W        (FB_W),
        .FB_H        (FB_H),
        .COLOR_W     (8),
        .CLEAR_COLOR (CLR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .vsync      (vsync),
        .draw_valid (draw_valid),
        .draw_ready (draw_ready),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_color (draw_color),
        .fb_we      (fb_we),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .fb_wdata   (fb_wdata),
        .busy       (busy),
        .clear_done (clear_done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (clear_done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Checks one full sweep starting at the current cycle (write 0 on bus).
    // clear_req is pulsed during sweep writes req_a and req_b.
    task automatic sweep_check(input bit first_done, input int req_a, input int req_b);
        for (int k = 0; k < NPIX; k++) begin
            check_eq("sweep_we",    32'(fb_we),      32'd1);
            check_eq("sweep_x",     32'(fb_x),       32'(k % FB_W));
            check_eq("sweep_y",     32'(fb_y),       32'(k / FB_W));
            check_eq("sweep_data",  32'(fb_wdata),   32'(CLR));
            check_eq("sweep_busy",  32'(busy),       32'd1);
            check_eq("sweep_ready", 32'(draw_ready), 32'd0);
            check_eq("sweep_done",  32'(clear_done), (k == 0) ? 32'(first_done) : 32'd0);
            clear_req = (k == req_a) || (k == req_b);
            step();
            clear_req = 1'b0;
        end
    endtask

    initial begin
        int base;
        int stray;
        reset = 1'b1; clear_req = 1'b0; vsync = 1'b0; draw_valid = 1'b0;
        draw_x = '0; draw_y = '0; draw_color = '0;
        repeat (3) step();
        reset = 1'b0;
        #1;

        // Reset state
        check_eq("rst_we",    32'(fb_we),      32'd0);
        check_eq("rst_x",     32'(fb_x),       32'd0);
        check_eq("rst_wdata", 32'(fb_wdata),   32'd0);
        check_eq("rst_busy",  32'(busy),       32'd0);
        check_eq("rst_done",  32'(clear_done), 32'd0);
        check_eq("rst_ready", 32'(draw_ready), 32'd1);

        // Draw in IDLE
        draw_valid = 1'b1; draw_x = 11'd10; draw_y = 11'd20; draw_color = 8'hAB;
        #1;
        check_eq("draw_ready", 32'(draw_ready), 32'd1);
        step();
        draw_valid = 1'b0;
        check_eq("draw_we",   32'(fb_we),    32'd1);
        check_eq("draw_x",    32'(fb_x),     32'd10);
        check_eq("draw_y",    32'(fb_y),     32'd20);
        check_eq("draw_data", 32'(fb_wdata), 32'hAB);
        step();
        check_eq("draw_we_off", 32'(fb_we), 32'd0);

`ifdef FB_CLEAR_SYNC_EN
        // Clear waits for vsync; draws continue meanwhile
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check_eq("ws_busy", 32'(busy),  32'd1);
        check_eq("ws_we",   32'(fb_we), 32'd0);
        draw_valid = 1'b1; draw_x = 11'd5; draw_y = 11'd6; draw_color = 8'h77;
        #1;
        check_eq("ws_ready", 32'(draw_ready), 32'd1);
        step();
        draw_valid = 1'b0;
        check_eq("ws_draw_we", 32'(fb_we), 32'd1);
        check_eq("ws_draw_x",  32'(fb_x),  32'd5);
        check_eq("ws_draw_d",  32'(fb_wdata), 32'h77);
        repeat (5) step();
        draw_valid = 1'b1; vsync = 1'b1;
        #1;
        check_eq("ws_vsync_ready", 32'(draw_ready), 32'd0);
        step();
        vsync = 1'b0; draw_valid = 1'b0;
        sweep_check(1'b0, -1, -1);
        check_eq("ws_done", 32'(clear_done), 32'd1);
        check_eq("ws_idle_busy", 32'(busy), 32'd0);
        step();
`else
        // vsync is ignored without the sync feature
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        check_eq("vsync_busy", 32'(busy),  32'd0);
        check_eq("vsync_we",   32'(fb_we), 32'd0);

        // Single clear: writes start the cycle after the request
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        sweep_check(1'b0, -1, -1);
        check_eq("clr_end_we",    32'(fb_we),      32'd0);
        check_eq("clr_end_done",  32'(clear_done), 32'd1);
        check_eq("clr_end_busy",  32'(busy),       32'd0);
        check_eq("clr_end_ready", 32'(draw_ready), 32'd1);
        step();
        check_eq("clr_done_off", 32'(clear_done), 32'd0);

        // clear_req and draw_valid together: clear wins, draw waits
        clear_req = 1'b1; draw_valid = 1'b1;
        draw_x = 11'd7; draw_y = 11'd8; draw_color = 8'h11;
        #1;
        check_eq("coll_ready", 32'(draw_ready), 32'd0);
        step();
        clear_req = 1'b0;
        sweep_check(1'b0, -1, -1);
        check_eq("coll_done",  32'(clear_done), 32'd1);
        check_eq("coll_ready2", 32'(draw_ready), 32'd1);
        step();
        draw_valid = 1'b0;
        check_eq("coll_we",   32'(fb_we),    32'd1);
        check_eq("coll_x",    32'(fb_x),     32'd7);
        check_eq("coll_y",    32'(fb_y),     32'd8);
        check_eq("coll_data", 32'(fb_wdata), 32'h11);
        step();

        // Two requests mid-sweep merge into one back-to-back sweep
        base = done_cnt;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        sweep_check(1'b0, 3, 7);
        sweep_check(1'b1, -1, -1);
        check_eq("dbl_done", 32'(clear_done), 32'd1);
        check_eq("dbl_we",   32'(fb_we),      32'd0);
        check_eq("dbl_busy", 32'(busy),       32'd0);
        step();
        check_eq("dbl_no_third", 32'(fb_we), 32'd0);
        check_eq("dbl_pulses",   32'(done_cnt - base), 32'd2);

        // Reset at sweep write 5 aborts the sweep cleanly
        base = done_cnt;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (5) step();
        check_eq("rs_x5", 32'(fb_x), 32'd1);
        check_eq("rs_y5", 32'(fb_y), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rs_we",   32'(fb_we),      32'd0);
        check_eq("rs_busy", 32'(busy),       32'd0);
        check_eq("rs_done", 32'(clear_done), 32'd0);
        stray = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (fb_we || clear_done) stray++;
        end
        check_eq("rs_stray", 32'(stray), 32'd0);
        check_eq("rs_pulses", 32'(done_cnt - base), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
